// File: rtl/keypad_scanner.sv
// keypad_scanner -- 4x4 matrix keypad front end.
//
// Drives one row at a time (one-hot), samples the synchronized column lines
// once per row slot, debounces press and release, and hands out one decoded
// key code per press over a valid/ready pair.
//
// Optional feature: define KEYPAD_REPEAT_EN to re-emit a held key every
// REPEAT_CNT matching samples. Without it exactly one code is emitted per
// press and no repeat logic exists.
//
// Parameters:
//   BASE          key layout for keypad_decoder (16 = hex grid, 10 = phone pad)
//   SCAN_DIV      clk cycles per row slot (>= 4)
//   DEBOUNCE_CNT  consecutive matching samples to accept press/release (>= 1)
//   REPEAT_CNT    samples between auto-repeats (KEYPAD_REPEAT_EN only)
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   col_in     raw column lines, active-high, asynchronous to clk
//   row_drive  one-hot row drive
//   key_value  decoded key, stable while key_valid
//   key_valid  key available, held until accepted
//   key_ready  consumer accepts on key_valid & key_ready
//   key_held   high while a debounced key is down
//   overrun    sticky flag: a key was dropped while one was pending

// Converts a one-hot row/column pair into a 4-bit key code.
module keypad_decoder #(
    parameter int BASE = 16
) (
    input  logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] value
);
    logic [1:0] r, c;

    always_comb begin
        r = 2'd0;
        c = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (row[i]) r = 2'(i);
            if (col[i]) c = 2'(i);
        end
        if (BASE == 16) begin
            value = {r, c};
        end else begin
            // Phone-style pad: 1-9 in the 3x3 block, 0 under 8, A-D down
            // the right column, '*' -> 14 and '#' -> 15.
            if (r != 2'd3 && c != 2'd3)
                value = 4'(3 * int'(r) + int'(c) + 1);
            else if (c == 2'd3)
                value = 4'd10 + {2'b00, r};
            else if (c == 2'd0)
                value = 4'd14;
            else if (c == 2'd1)
                value = 4'd0;
            else
                value = 4'd15;
        end
    end
endmodule

module keypad_scanner #(
    parameter int BASE         = 16,
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3,
    parameter int REPEAT_CNT   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_drive,
    output logic [3:0] key_value,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun
);
    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_CNT < 1) begin : g_param_chk
        $error("keypad_scanner: illegal parameter value");
    end

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t        state, state_n;
    logic [3:0]    col_m, col_s;
    logic [DW-1:0] div;
    // Only the column half of the latched code is stored: the row stays
    // frozen on row_drive for as long as the code is in use.
    logic [3:0]    code, code_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          held_n;
    logic          sample, rotate, emit, accept;
    logic [3:0]    dec_value;

    assign sample = (div == DIV_LAST);
    assign accept = key_valid & key_ready;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = (REPEAT_CNT > 1) ? $clog2(REPEAT_CNT) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CNT - 1);
    logic [RW-1:0] rep_cnt, rep_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rep_cnt <= '0;
        else        rep_cnt <= rep_n;
    end
`endif

    // At every emit the live sample equals the code and the row is frozen
    // on the key's row, so the decoder can look straight at the pins.
    keypad_decoder #(.BASE(BASE)) u_dec (
        .row   (row_drive),
        .col   (col_s),
        .value (dec_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SCAN;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        code_n  = code;
        cnt_n   = cnt;
        held_n  = key_held;
        rotate  = 1'b0;
        emit    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_n   = rep_cnt;
`endif
        if (sample) begin
            case (state)
                SCAN: begin
                    if ($onehot(col_s)) begin
                        code_n = col_s;
                        if (DEBOUNCE_CNT == 1) begin
                            emit    = 1'b1;
                            held_n  = 1'b1;
                            cnt_n   = '0;
                            state_n = HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_n   = '0;
`endif
                        end else begin
                            cnt_n   = CW'(1);
                            state_n = DEBOUNCE;
                        end
                    end else begin
                        rotate = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (col_s == code) begin
                        if (cnt == DB_LAST) begin
                            emit    = 1'b1;
                            held_n  = 1'b1;
                            cnt_n   = '0;
                            state_n = HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_n   = '0;
`endif
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end else begin
                        cnt_n   = '0;
                        rotate  = 1'b1;
                        state_n = SCAN;
                    end
                end
                HELD: begin
                    // cnt counts consecutive all-zero samples; any contact
                    // (bounce or a second key) restarts the release window.
                    if (col_s == 4'b0000) begin
                        if (cnt == DB_LAST) begin
                            held_n  = 1'b0;
                            cnt_n   = '0;
                            rotate  = 1'b1;
                            state_n = SCAN;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end else begin
                        cnt_n = '0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    if (col_s == code) begin
                        if (rep_cnt == REP_LAST) begin
                            emit  = 1'b1;
                            rep_n = '0;
                        end else begin
                            rep_n = rep_cnt + 1'b1;
                        end
                    end else begin
                        rep_n = '0;
                    end
`endif
                end
                default: state_n = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_m     <= 4'b0000;
            col_s     <= 4'b0000;
            div       <= '0;
            row_drive <= 4'b0001;
            code      <= 4'b0000;
            cnt       <= '0;
            key_held  <= 1'b0;
        end else begin
            col_m     <= col_in;
            col_s     <= col_m;
            div       <= sample ? '0 : div + 1'b1;
            if (rotate) row_drive <= {row_drive[2:0], row_drive[3]};
            code      <= code_n;
            cnt       <= cnt_n;
            key_held  <= held_n;
        end
    end

    // Output handshake: an emit is loaded when the slot is free or being
    // freed this cycle; otherwise it is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_value <= 4'd0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (emit && (!key_valid || accept)) begin
                key_value <= dec_value;
                key_valid <= 1'b1;
            end else if (accept) begin
                key_valid <= 1'b0;
            end
            if (emit && key_valid && !accept) overrun <= 1'b1;
            else if (accept)                  overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
module tb_keypad_scanner;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] col_in;
    logic [3:0] row_drive;
    logic [3:0] key_value;
    logic       key_valid;
    logic       key_ready = 1'b1;
    logic       key_held;
    logic       overrun;

    keypad_scanner #(.BASE(16), .SCAN_DIV(4), .DEBOUNCE_CNT(3), .REPEAT_CNT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_in    (col_in),
        .row_drive (row_drive),
        .key_value (key_value),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Physical keypad: key pkey (row = pkey/4, col = pkey%4) connects its
    // row line to its column line while pressed.
    logic       pressed = 1'b0;
    logic [3:0] pkey = 4'd0;
    always_comb
        col_in = (pressed && row_drive == (4'b0001 << pkey[3:2])) ? (4'b0001 << pkey[1:0]) : 4'b0000;

    // Every accepted key, in order.
    logic [3:0] acc_q[$];
    always @(posedge clk)
        if (rst_n && key_valid && key_ready) acc_q.push_back(key_value);

    int n_chk = 0, n_fail = 0, edges = 0;
    bit rnd_rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; leaves time 1ns past the edge for sampling and driving.
    task automatic tick();
        @(posedge clk);
        edges++;
        #1;
        if (rnd_rdy) key_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Edges are counted from reset release; with SCAN_DIV=4 every 4th edge samples.
    task automatic to_edge(input int e);
        while (edges < e) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        edges = 0;
    endtask

    task automatic wait_held(input logic v, input string tag);
        int n = 0;
        while (key_held !== v && n < 400) begin
            tick();
            n++;
        end
        chk(tag, 32'(key_held), 32'(v));
    endtask

    logic [3:0] exp_q[$];
    int exp_rep;

    initial begin
        // ---- reset values, rotation, reset mid-operation ----
        #1 rst_n = 1'b0;
        #1;
        chk("rst_row", 32'(row_drive), 1);
        chk("rst_valid", 32'(key_valid), 0);
        chk("rst_value", 32'(key_value), 0);
        chk("rst_held", 32'(key_held), 0);
        chk("rst_ovr", 32'(overrun), 0);
        ticks(2);
        rst_n = 1'b1;
        edges = 0;
        to_edge(5);
        chk("rot_1", 32'(row_drive), 2);
        to_edge(9);
        chk("rot_2", 32'(row_drive), 4);
        to_edge(13);
        chk("rot_3", 32'(row_drive), 8);
        to_edge(17);
        chk("rot_wrap", 32'(row_drive), 1);

        key_ready = 1'b0;
        pkey = 4'd0;
        do_reset();
        pressed = 1'b1;
        to_edge(12);
        chk("pend_valid", 32'(key_valid), 1);
        chk("pend_held", 32'(key_held), 1);
        tick();
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(key_valid), 0);
        chk("mid_rst_held", 32'(key_held), 0);
        chk("mid_rst_row", 32'(row_drive), 1);
        pressed = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        edges = 0;
        key_ready = 1'b1;

        // ---- press key 6, exact latency, then release ----
        do_reset();
        acc_q.delete();
        pkey = 4'd6;
        pressed = 1'b1;
        to_edge(12);
        chk("p6_early", 32'(key_valid), 0);
        to_edge(16);
        chk("p6_valid", 32'(key_valid), 1);
        chk("p6_value", 32'(key_value), 6);
        chk("p6_held", 32'(key_held), 1);
        chk("p6_row", 32'(row_drive), 2);
        to_edge(17);
        chk("p6_accept", 32'(key_valid), 0);
        to_edge(40);
        chk("p6_once", acc_q.size(), 1);
        chk("p6_frozen", 32'(row_drive), 2);
        pressed = 1'b0;
        to_edge(48);
        chk("rel_still", 32'(key_held), 1);
        to_edge(52);
        chk("rel_held", 32'(key_held), 0);
        chk("rel_row", 32'(row_drive), 4);
        to_edge(56);
        chk("rel_rot", 32'(row_drive), 8);
        to_edge(80);
        chk("rel_no2nd", acc_q.size(), 1);
        if (acc_q.size() > 0) chk("rel_key", 32'(acc_q[0]), 6);

        // ---- bounce: contact alternates every sample ----
        do_reset();
        acc_q.delete();
        pkey = 4'd6;
        for (int s = 1; s <= 14; s++) begin
            to_edge(4 * s);
            if (s == 3) chk("bnc_resume", 32'(row_drive), 4);
            pressed = (s % 2 == 1);
        end
        to_edge(64);
        chk("bnc_none", acc_q.size(), 0);
        chk("bnc_held", 32'(key_held), 0);
        pressed = 1'b1;
        wait_held(1'b1, "bnc_stable");
        chk("bnc_valid", 32'(key_valid), 1);
        chk("bnc_value", 32'(key_value), 6);
        pressed = 1'b0;
        wait_held(1'b0, "bnc_rel");

        // ---- overrun: 0 pending, 5 dropped ----
        do_reset();
        acc_q.delete();
        key_ready = 1'b0;
        pkey = 4'd0;
        pressed = 1'b1;
        wait_held(1'b1, "ovr_hold0");
        chk("ovr_v0", 32'(key_value), 0);
        pressed = 1'b0;
        wait_held(1'b0, "ovr_rel0");
        pkey = 4'd5;
        pressed = 1'b1;
        wait_held(1'b1, "ovr_hold5");
        chk("ovr_flag", 32'(overrun), 1);
        chk("ovr_keep", 32'(key_value), 0);
        chk("ovr_pend", 32'(key_valid), 1);
        ticks(3);
        chk("ovr_sticky", 32'(overrun), 1);
        key_ready = 1'b1;
        tick();
        chk("ovr_acc_valid", 32'(key_valid), 0);
        chk("ovr_acc_clr", 32'(overrun), 0);
        pressed = 1'b0;
        wait_held(1'b0, "ovr_rel5");
        chk("ovr_cnt", acc_q.size(), 1);

        // ---- hold F for 20 samples after emit ----
        do_reset();
        acc_q.delete();
        pkey = 4'd15;
        pressed = 1'b1;
        wait_held(1'b1, "rep_hold");
        ticks(80);
        pressed = 1'b0;
        wait_held(1'b0, "rep_rel");
        tick();
`ifdef KEYPAD_REPEAT_EN
        exp_rep = 3;
`else
        exp_rep = 1;
`endif
        chk("rep_pulses", acc_q.size(), exp_rep);
        foreach (acc_q[i]) chk("rep_key", 32'(acc_q[i]), 15);

        // ---- random presses, bounce and backpressure vs key sequence ----
        do_reset();
        acc_q.delete();
        exp_q.delete();
        rnd_rdy = 1'b1;
        for (int p = 0; p < 24; p++) begin
            int nb, ns;
            pkey = 4'($urandom_range(0, 15));
            exp_q.push_back(pkey);
            ticks($urandom_range(0, 3));
`ifdef KEYPAD_REPEAT_EN
            nb = 0;
            ns = 9;
`else
            nb = $urandom_range(0, 6);
            ns = $urandom_range(10, 16);
`endif
            repeat (nb) begin
                pressed = 1'($urandom_range(0, 1));
                tick();
            end
            pressed = 1'b1;
            ticks(4 * ns);
            pressed = 1'b0;
            ticks(4 * $urandom_range(5, 8));
        end
        rnd_rdy = 1'b0;
        key_ready = 1'b1;
        ticks(8);
        chk("rnd_count", acc_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
            chk("rnd_key", 32'(acc_q[i]), 32'(exp_q[i]));
        chk("rnd_ovr", 32'(overrun), 0);
        chk("rnd_idle", 32'(key_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
